// File: rtl/mem_access_ctrl_if.sv
// Request, response and memory-port bundle for mem_access_ctrl.
// The signal names inside the bundle keep the original port names of the block.
// The slave modport is the controller's view.
// The master modport is the requester/memory view.
interface mem_access_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_mode_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_mode_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_mode_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/half/word load-store controller for a 32-bit word memory.
// It issues one or two word strobes per request and returns extended load data
// with a one-cycle response pulse.
// Optional feature: when MEM_MISALIGN_SPLIT_EN is defined, an access that
// crosses a word boundary is split into two word accesses. Without the macro,
// such an access is rejected with rsp_err_o.
module mem_access_ctrl (
  input logic              clock_i,
  input logic              reset_ni,
  mem_access_ctrl_if.slave bus
);

`ifdef MEM_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  mode_q, mode_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  mask_q, mask_d;
  logic        err_q, err_d;
  logic [31:0] lo_q, lo_d;
  // Only the low three bytes of the high word can ever reach the result.
  logic [23:0] hi_q, hi_d;

  logic [7:0]  req_mask;
  logic        req_split;
  logic        split_go;
  logic [31:0] wdata_rot;
  logic [31:0] load_sel;
  logic [31:0] load_ext;

  logic        ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;

  // Byte-lane mask of the incoming request, widened to two words.
  always_comb begin
    req_mask = 8'h00;
    case (bus.req_mode_i)
      2'b00:   req_mask = 8'h01 << bus.req_addr_i[1:0];
      2'b01:   req_mask = 8'h03 << bus.req_addr_i[1:0];
      2'b10:   req_mask = 8'h0F << bus.req_addr_i[1:0];
      default: req_mask = 8'h00;
    endcase
    req_split = |req_mask[7:4];
  end

  assign split_go = SplitEn && (|mask_q[7:4]);

  // Store data rotated into its byte lanes. The same value serves both strobes.
  always_comb begin
    wdata_rot = wdata_q;
    case (addr_q[1:0])
      2'd0:    wdata_rot = wdata_q;
      2'd1:    wdata_rot = {wdata_q[23:0], wdata_q[31:24]};
      2'd2:    wdata_rot = {wdata_q[15:0], wdata_q[31:16]};
      default: wdata_rot = {wdata_q[7:0],  wdata_q[31:8]};
    endcase
  end

  // Extract the addressed bytes from {high, low} and extend them to 32 bits.
  always_comb begin
    load_sel = lo_q;
    case (addr_q[1:0])
      2'd0:    load_sel = lo_q;
      2'd1:    load_sel = {hi_q[7:0],  lo_q[31:8]};
      2'd2:    load_sel = {hi_q[15:0], lo_q[31:16]};
      default: load_sel = {hi_q[23:0], lo_q[31:24]};
    endcase
    load_ext = load_sel;
    case (mode_q)
      2'b00:   load_ext = uns_q ? {24'h0, load_sel[7:0]}
                                : {{24{load_sel[7]}}, load_sel[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, load_sel[15:0]}
                                : {{16{load_sel[15]}}, load_sel[15:0]};
      default: load_ext = load_sel;
    endcase
  end

  // Next-state, request latching and output decode.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    mode_d    = mode_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    err_d     = err_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    ready     = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid_i) begin
          we_d    = bus.req_we_i;
          mode_d  = bus.req_mode_i;
          uns_d   = bus.req_unsigned_i;
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          mask_d  = req_mask;
          lo_d    = '0;
          hi_d    = '0;
          err_d   = (bus.req_mode_i == 2'b11) || (req_split && !SplitEn);
          state_d = ((bus.req_mode_i == 2'b11) || (req_split && !SplitEn)) ? RESP : ISSUE0;
        end
      end
      ISSUE0: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_be    = mask_q[3:0];
        mem_addr  = addr_q[31:2];
        mem_wdata = wdata_rot;
        if (!we_q)         state_d = WAIT0;
        else if (split_go) state_d = ISSUE1;
        else               state_d = RESP;
      end
      WAIT0: begin
        lo_d    = bus.mem_rdata_i;
        state_d = split_go ? ISSUE1 : RESP;
      end
      ISSUE1: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_be    = mask_q[7:4];
        mem_addr  = addr_q[31:2] + 30'd1;
        mem_wdata = wdata_rot;
        state_d   = we_q ? RESP : WAIT1;
      end
      WAIT1: begin
        hi_d    = bus.mem_rdata_i[23:0];
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (we_q || err_q) ? '0 : load_ext;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      mode_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_err_o   = rsp_err;
  assign bus.rsp_rdata_o = rsp_rdata;
  assign bus.mem_en_o    = mem_en;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_be_o    = mem_be;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;

endmodule
